// File: rtl/aes_arb_pkg.sv
`timescale 1ns/1ps
// Shared types and widths for the AES request arbiter.
package aes_arb_pkg;

    localparam int unsigned AES_BLK_W  = 128;
    localparam int unsigned JOBS_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/aes_req_arbiter_rr_pick.sv
`timescale 1ns/1ps
// Combinational round-robin picker: grants the first requester found at or
// after ptr, wrapping from N_REQ-1 back to 0.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the requesters starting at ptr; the first active one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = ptr;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
            idx = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
`timescale 1ns/1ps
// Shares one AES core between N_REQ requesters: round-robin grant, latch the
// job, launch the core, wait for a fresh done edge (or watchdog timeout) and
// return the result to the owner over a valid/ready handshake.
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [AES_BLK_W*N_REQ-1:0]   req_plain_text,
    input  logic [AES_BLK_W*N_REQ-1:0]   req_cipher_key,
    output logic [N_REQ-1:0]             rsp_valid,
    input  logic [N_REQ-1:0]             rsp_ready,
    output logic [AES_BLK_W-1:0]         rsp_cipher_text,
    output logic                         rsp_err,
    output logic                         aes_start,
    output logic [AES_BLK_W-1:0]         aes_plain_text,
    output logic [AES_BLK_W-1:0]         aes_cipher_key,
    input  logic                         aes_done,
    input  logic [AES_BLK_W-1:0]         aes_cipher_text,
    output logic [JOBS_CNT_W-1:0]        jobs_done
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    arb_state_e       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    owner_idx;
    logic [N_REQ-1:0] owner_oh;
    logic [TW-1:0]    timer;
    logic             done_q;

    logic [N_REQ-1:0] pick_grant;
    logic [PW-1:0]    pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PW)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // Grant is only offered while idle; gated by rstn so it reads 0 during reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && rstn)
            req_ready = pick_grant;
    end

    // Arbitration FSM with job latches, watchdog timer and completion counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            owner_idx       <= '0;
            owner_oh        <= '0;
            timer           <= '0;
            done_q          <= 1'b0;
            rsp_valid       <= '0;
            rsp_cipher_text <= '0;
            rsp_err         <= 1'b0;
            aes_start       <= 1'b0;
            aes_plain_text  <= '0;
            aes_cipher_key  <= '0;
            jobs_done       <= '0;
        end else begin
            done_q    <= aes_done;
            aes_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pick_grant) begin
                        for (int unsigned i = 0; i < N_REQ; i++) begin
                            if (pick_grant[i]) begin
                                aes_plain_text <= req_plain_text[i*AES_BLK_W +: AES_BLK_W];
                                aes_cipher_key <= req_cipher_key[i*AES_BLK_W +: AES_BLK_W];
                            end
                        end
                        owner_idx <= pick_idx;
                        owner_oh  <= pick_grant;
                        aes_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    // A fresh done edge takes priority over a simultaneous timeout.
                    if (aes_done && !done_q) begin
                        rsp_cipher_text <= aes_cipher_text;
                        rsp_err         <= 1'b0;
                        rsp_valid       <= owner_oh;
                        state           <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_cipher_text <= '0;
                        rsp_err         <= 1'b1;
                        rsp_valid       <= owner_oh;
                        state           <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (|(rsp_ready & owner_oh)) begin
                        rsp_valid <= '0;
                        jobs_done <= jobs_done + 1'b1;
                        rr_ptr    <= (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
